inst_load_mem: RTL and testbench
================================

INST_LOAD_MEM -- requirements
Module: inst_load_mem

Interface
REQ-001 The block SHALL take parameter cXLEN, default 32, giving the instruction word width in bits.
REQ-002 The block SHALL take parameter cDepth, default 256, giving the instruction store size in words; it is a power of two and at least 4.
REQ-003 The block SHALL have port iClk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port iRst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port iStart, input, 1 bit: level request to leave loading and begin serving fetches.
REQ-006 The block SHALL have port iInst2Write, input, cXLEN bits: instruction word to store.
REQ-007 The block SHALL have port iInstWen, input, 1 bit: write strobe for iInst2Write.
REQ-008 The block SHALL have port iFetchReq, input, 1 bit: fetch request.
REQ-009 The block SHALL have port iFetchAddr, input, cXLEN bits: fetch byte address (PC).
REQ-010 The block SHALL have port oFetchInst, output, cXLEN bits: fetched instruction.
REQ-011 The block SHALL have port oFetchDv, output, 1 bit: oFetchInst valid.
REQ-012 The block SHALL have port oFetchErr, output, 1 bit: the fetch was out of range or misaligned.
REQ-013 The block SHALL have port oLoadCnt, output, clog2(cDepth)+1 bits: number of words loaded.
REQ-014 The block SHALL have port oLoadFull, output, 1 bit: oLoadCnt equals cDepth.
REQ-015 The block SHALL have port oLoadOvf, output, 1 bit: sticky flag, a write was dropped while full.
REQ-016 The block SHALL have port oRunning, output, 1 bit: the state is RUN.

Function
REQ-017 The block SHALL implement two states: LOAD, which is the reset state, and RUN.
REQ-018 In LOAD with iInstWen=1 and not full, the block SHALL write iInst2Write to word oLoadCnt and increment oLoadCnt; the new count is visible the next cycle.
REQ-019 In LOAD with iInstWen=1 and full, the block SHALL leave memory and oLoadCnt unchanged and set oLoadOvf.
REQ-020 In LOAD with iStart=1, the block SHALL enter RUN on the next cycle; if iInstWen=1 in the same cycle, the write SHALL still be performed.
REQ-021 In RUN, the block SHALL ignore iInstWen and remain in RUN until reset, whatever the level of iStart.
REQ-022 In LOAD, the block SHALL ignore iFetchReq and hold oFetchDv=0.
REQ-023 In RUN, each iFetchReq=1 SHALL produce oFetchDv=1 exactly one cycle later, with oFetchInst equal to the word at index iFetchAddr[clog2(cDepth)+1:2]; back-to-back requests SHALL give back-to-back responses.
REQ-024 When no request was made in the previous cycle, the block SHALL drive oFetchDv=0 and hold oFetchInst at its last value.
REQ-025 A write and a fetch SHALL never conflict, because writes occur only in LOAD and fetches only in RUN.

Reset
REQ-026 While iRst=1, the block SHALL set state=LOAD, oLoadCnt=0, oLoadOvf=0, oFetchDv=0, oFetchErr=0 and oFetchInst=0; oLoadFull and oRunning SHALL read 0 as a result.
REQ-027 A reset during LOAD or RUN SHALL discard the in-flight fetch and SHALL NOT clear memory contents.
REQ-028 A reload after reset SHALL overwrite memory from word 0.

Configuration
REQ-029 With macro INST_BOUNDS_CHECK_EN defined, a RUN fetch SHALL return 32'h00000013 (NOP) with oFetchErr=1 when the word index is greater than or equal to oLoadCnt, or when iFetchAddr[1:0] is not 0, or when iFetchAddr is at or above cDepth*4.
REQ-030 Without INST_BOUNDS_CHECK_EN, oFetchErr SHALL be tied to 0, the address SHALL wrap modulo cDepth words, iFetchAddr[1:0] SHALL be ignored, and the raw memory word SHALL be returned.

Verification
REQ-031 Load: reset, then write 0x00500093 and 0x00A00113 in consecutive cycles, then iStart=1 -> oLoadCnt=2, oRunning=1 on the cycle after iStart.
REQ-032 Fetch: in RUN, requests at addresses 0x0 and 0x4 back-to-back -> oFetchDv high for 2 cycles, returning 0x00500093 then 0x00A00113, each 1 cycle after its request.
REQ-033 Overflow: cDepth=4, write 5 words -> oLoadCnt=4, oLoadFull=1, oLoadOvf=1, word 3 holds the 4th value.
REQ-034 Simultaneous events: iInstWen=1 with 0xDEADBEEF and iStart=1 in the same cycle -> oLoadCnt increments and the state is RUN next cycle; a later iInstWen in RUN has no effect.
REQ-035 Bounds (INST_BOUNDS_CHECK_EN): with 2 words loaded, fetch 0x8 -> 0x00000013, oFetchErr=1; fetch 0x2 -> NOP, oFetchErr=1. Without the macro, cDepth=4, fetch 0x10 -> word 0, oFetchErr=0.
REQ-036 Reset mid-run: assert iRst in the cycle following a fetch request -> oFetchDv=0, state=LOAD, oLoadCnt=0; a reload of 1 word then a fetch of 0x4 returns stale word 1 without the macro and NOP with oFetchErr=1 with it.

Source files
------------

// File: rtl/inst_load_mem.sv
// Instruction store: loads words sequentially in LOAD, then serves one-cycle fetches in RUN.
// Optional fetch bounds/alignment checking is enabled with macro INST_BOUNDS_CHECK_EN.
module inst_load_mem #(
  parameter int cXLEN  = 32,
  parameter int cDepth = 256
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic                       iStart,
  input  logic [cXLEN-1:0]           iInst2Write,
  input  logic                       iInstWen,
  input  logic                       iFetchReq,
  input  logic [cXLEN-1:0]           iFetchAddr,
  output logic [cXLEN-1:0]           oFetchInst,
  output logic                       oFetchDv,
  output logic                       oFetchErr,
  output logic [$clog2(cDepth):0]    oLoadCnt,
  output logic                       oLoadFull,
  output logic                       oLoadOvf,
  output logic                       oRunning
);

  localparam int                AW       = $clog2(cDepth);
  localparam logic [AW:0]       CNT_FULL = (AW+1)'(cDepth);
  localparam logic [cXLEN-1:0]  NOP      = cXLEN'(32'h0000_0013);

  typedef enum logic {LOAD, RUN} state_t;

  state_t            state_q, state_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              dv_q, dv_d;
  logic              err_q, err_d;
  logic [cXLEN-1:0]  inst_q, inst_d;
  logic [cXLEN-1:0]  mem_q [0:cDepth-1];
  logic              wr_en;
  logic              full;
  logic              fetch_bad;
  logic [AW-1:0]     idx;

  assign idx  = iFetchAddr[AW+1:2];
  assign full = (cnt_q == CNT_FULL);

`ifdef INST_BOUNDS_CHECK_EN
  // Out of range: beyond the store, beyond what was loaded, or not word aligned.
  function automatic logic fetch_oob(input logic [cXLEN-1:0] addr, input logic [AW:0] cnt);
    logic [AW-1:0] w;
    w = addr[AW+1:2];
    fetch_oob = (|addr[cXLEN-1:AW+2]) || (|addr[1:0]) || ({1'b0, w} >= cnt);
  endfunction

  assign fetch_bad = fetch_oob(iFetchAddr, cnt_q);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{iFetchAddr[cXLEN-1:AW+2], iFetchAddr[1:0]};
  assign fetch_bad        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    dv_d    = 1'b0;
    err_d   = 1'b0;
    inst_d  = inst_q;
    wr_en   = 1'b0;
    case (state_q)
      LOAD: begin
        if (iInstWen) begin
          if (!full) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (iStart) state_d = RUN;
      end
      RUN: begin
        if (iFetchReq) begin
          dv_d = 1'b1;
          if (fetch_bad) begin
            inst_d = NOP;
            err_d  = 1'b1;
          end else begin
            inst_d = mem_q[idx];
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
      inst_q  <= inst_d;
    end
  end

  // Memory contents survive reset; only the write pointer is cleared.
  always_ff @(posedge iClk) begin
    if (wr_en && !iRst) mem_q[cnt_q[AW-1:0]] <= iInst2Write;
  end

  assign oFetchInst = inst_q;
  assign oFetchDv   = dv_q;
  assign oFetchErr  = err_q;
  assign oLoadCnt   = cnt_q;
  assign oLoadFull  = full;
  assign oLoadOvf   = ovf_q;
  assign oRunning   = (state_q == RUN);

endmodule

// File: tb/tb_inst_load_mem.sv
// Directed self-checking bench for inst_load_mem (cDepth=4); expectations follow INST_BOUNDS_CHECK_EN.
module tb_inst_load_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] wdata = '0;
  logic        wen = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] inst;
  logic        dv, err, full, ovf, running;
  logic [2:0]  cnt;

  int n_tests = 0;
  int n_fail  = 0;

  inst_load_mem #(.cXLEN(32), .cDepth(4)) dut (
    .iClk(clk), .iRst(rst), .iStart(start), .iInst2Write(wdata), .iInstWen(wen),
    .iFetchReq(req), .iFetchAddr(addr), .oFetchInst(inst), .oFetchDv(dv),
    .oFetchErr(err), .oLoadCnt(cnt), .oLoadFull(full), .oLoadOvf(ovf), .oRunning(running)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wen = 1'b1; wdata = 32'hFFFF_FFFF;
    tick(); tick();
    wen = 1'b0;
    n_tests++; if (cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
    n_tests++; if ({dv, err, ovf, full, running} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 00000", {dv, err, ovf, full, running}); end
    n_tests++; if (inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h expected 00000000", inst); end
    rst = 1'b0;
  endtask

  task automatic test_load();
    wen = 1'b1; wdata = 32'h0050_0093; req = 1'b1; addr = 32'h0;
    tick();
    n_tests++; if (dv !== 1'b0) begin n_fail++; $display("FAIL load_fetch_ignored: got dv=%b expected 0", dv); end
    req = 1'b0; wdata = 32'h00A0_0113;
    tick();
    wen = 1'b0;
    n_tests++; if (cnt !== 3'd2 || running !== 1'b0) begin n_fail++; $display("FAIL load_cnt: got cnt=%0d run=%b expected cnt=2 run=0", cnt, running); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++; if (cnt !== 3'd2 || running !== 1'b1) begin n_fail++; $display("FAIL load_start: got cnt=%0d run=%b expected cnt=2 run=1", cnt, running); end
  endtask

  task automatic test_back_to_back();
    req = 1'b1; addr = 32'h0;
    tick();
    n_tests++; if (dv !== 1'b1 || inst !== 32'h0050_0093 || err !== 1'b0) begin n_fail++; $display("FAIL fetch0: got dv=%b inst=%h err=%b expected 1 00500093 0", dv, inst, err); end
    addr = 32'h4;
    tick();
    n_tests++; if (dv !== 1'b1 || inst !== 32'h00A0_0113) begin n_fail++; $display("FAIL fetch4: got dv=%b inst=%h expected 1 00a00113", dv, inst); end
    req = 1'b0;
    tick();
    n_tests++; if (dv !== 1'b0 || inst !== 32'h00A0_0113) begin n_fail++; $display("FAIL fetch_hold: got dv=%b inst=%h expected 0 00a00113", dv, inst); end
  endtask

  task automatic test_bounds();
    logic [31:0] a [3];
    logic [31:0] ei [3];
    logic        ee [3];
`ifdef INST_BOUNDS_CHECK_EN
    a = '{32'h8, 32'h2, 32'h10};
    ei = '{32'h13, 32'h13, 32'h13};
    ee = '{1'b1, 1'b1, 1'b1};
`else
    a = '{32'h10, 32'h2, 32'h14};
    ei = '{32'h0050_0093, 32'h0050_0093, 32'h00A0_0113};
    ee = '{1'b0, 1'b0, 1'b0};
`endif
    req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = a[i];
      tick();
      n_tests++; if (dv !== 1'b1 || inst !== ei[i] || err !== ee[i]) begin n_fail++; $display("FAIL bounds_%h: got dv=%b inst=%h err=%b expected 1 %h %b", a[i], dv, inst, err, ei[i], ee[i]); end
    end
    req = 1'b0;
    tick();
    n_tests++; if (dv !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL bounds_idle: got dv=%b err=%b expected 0 0", dv, err); end
  endtask

  task automatic test_run_ignores_wen();
    wen = 1'b1; wdata = 32'hCAFE_F00D;
    tick(); tick();
    wen = 1'b0;
    n_tests++; if (cnt !== 3'd2 || running !== 1'b1) begin n_fail++; $display("FAIL run_wen: got cnt=%0d run=%b expected cnt=2 run=1", cnt, running); end
  endtask

  task automatic test_reset_midrun();
    req = 1'b1; addr = 32'h0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 1'b0;
    n_tests++; if (dv !== 1'b0 || running !== 1'b0 || cnt !== 3'd0 || err !== 1'b0) begin n_fail++; $display("FAIL midrun_reset: got dv=%b run=%b cnt=%0d err=%b expected 0 0 0 0", dv, running, cnt, err); end
    wen = 1'b1; wdata = 32'h1111_1111;
    tick();
    wen = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++; if (cnt !== 3'd1 || running !== 1'b1) begin n_fail++; $display("FAIL reload: got cnt=%0d run=%b expected 1 1", cnt, running); end
    req = 1'b1; addr = 32'h4;
    tick();
`ifdef INST_BOUNDS_CHECK_EN
    n_tests++; if (inst !== 32'h13 || err !== 1'b1 || dv !== 1'b1) begin n_fail++; $display("FAIL stale_word1: got inst=%h err=%b dv=%b expected 00000013 1 1", inst, err, dv); end
`else
    n_tests++; if (inst !== 32'h00A0_0113 || err !== 1'b0 || dv !== 1'b1) begin n_fail++; $display("FAIL stale_word1: got inst=%h err=%b dv=%b expected 00a00113 0 1", inst, err, dv); end
`endif
    addr = 32'h0;
    tick();
    req = 1'b0;
    n_tests++; if (inst !== 32'h1111_1111 || err !== 1'b0) begin n_fail++; $display("FAIL reload_word0: got inst=%h err=%b expected 11111111 0", inst, err); end
  endtask

  task automatic test_overflow();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wen = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wdata = 32'hA000_0000 + i;
      tick();
    end
    n_tests++; if (cnt !== 3'd4 || full !== 1'b1 || ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_full: got cnt=%0d full=%b ovf=%b expected 4 1 0", cnt, full, ovf); end
    wdata = 32'hA000_0004;
    tick();
    wen = 1'b0;
    n_tests++; if (cnt !== 3'd4 || full !== 1'b1 || ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got cnt=%0d full=%b ovf=%b expected 4 1 1", cnt, full, ovf); end
    start = 1'b1;
    tick();
    start = 1'b0; req = 1'b1; addr = 32'hC;
    tick();
    n_tests++; if (inst !== 32'hA000_0003 || err !== 1'b0) begin n_fail++; $display("FAIL ovf_word3: got inst=%h err=%b expected a0000003 0", inst, err); end
    addr = 32'h0;
    tick();
    req = 1'b0;
    n_tests++; if (inst !== 32'hA000_0000 || ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_word0: got inst=%h ovf=%b expected a0000000 1", inst, ovf); end
  endtask

  task automatic test_simultaneous();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wen = 1'b1; wdata = 32'h0050_0093;
    tick();
    wdata = 32'hDEAD_BEEF; start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++; if (cnt !== 3'd2 || running !== 1'b1) begin n_fail++; $display("FAIL simul_start: got cnt=%0d run=%b expected 2 1", cnt, running); end
    wdata = 32'h1234_5678;
    tick();
    wen = 1'b0;
    n_tests++; if (cnt !== 3'd2) begin n_fail++; $display("FAIL simul_run_wen: got cnt=%0d expected 2", cnt); end
    req = 1'b1; addr = 32'h4;
    tick();
    n_tests++; if (inst !== 32'hDEAD_BEEF || err !== 1'b0) begin n_fail++; $display("FAIL simul_word1: got inst=%h err=%b expected deadbeef 0", inst, err); end
    addr = 32'h8;
    tick();
    req = 1'b0;
`ifdef INST_BOUNDS_CHECK_EN
    n_tests++; if (inst !== 32'h13 || err !== 1'b1) begin n_fail++; $display("FAIL simul_word2: got inst=%h err=%b expected 00000013 1", inst, err); end
`else
    n_tests++; if (inst !== 32'hA000_0002 || err !== 1'b0) begin n_fail++; $display("FAIL simul_word2: got inst=%h err=%b expected a0000002 0", inst, err); end
`endif
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_bounds();
    test_run_ignores_wen();
    test_reset_midrun();
    test_overflow();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
